mem_wait_responder: RTL and testbench

- Memory-side responder for the multicycle RISC-V datapath's unified instruction/data memory port. This is the other end of the Adr/WriteData/MemWrite interface that the microprogrammed controller sequences.
- Services one word read or write at a time with a programmable number of wait states.
- Returns a single-cycle MemReady pulse, so a stalling controller can hold its microstate until the access completes.
- Holds a synchronous word-addressed storage array internally.

---
 rtl/mem_wait_responder.sv | 130 +++++++++++++
 tb/tb_mem_wait_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_responder.sv
// Memory-side responder for the multicycle datapath's unified memory port.
// Services one word access at a time, inserts WAIT wait states, then pulses MemReady.
module mem_wait_responder #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned WAIT       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemReq,
    input  logic             MemWrite,
    input  logic [31:0]      Adr,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] ReadData,
    output logic             MemReady,
    output logic             AdrErr,
    output logic             Busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT == 0) ? 0 : WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DEPTH_LOG2-1:0]   hold_idx;
    logic                    hold_mis;
    logic                    hold_write;
    logic [WIDTH-1:0]        hold_data;
    logic [WIDTH-1:0]        mem [DEPTH];

    logic                    accept;
    logic                    go_resp;
    logic                    commit_write;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic                    acc_mis;
    logic                    acc_write;
    logic                    adr_unused;

    // Upper address bits alias by design and take no part in decoding.
    assign adr_unused = ^Adr[31:DEPTH_LOG2+2];

    // With WAIT=0 the response is entered on the accepting edge, before the
    // holding registers are loaded, so the access fields come straight from the port.
    always_comb begin
        accept    = (state == ST_IDLE) && MemReq;
        acc_idx   = hold_idx;
        acc_mis   = hold_mis;
        acc_write = hold_write;
        if (state == ST_IDLE) begin
            acc_idx   = Adr[DEPTH_LOG2+1:2];
            acc_mis   = |Adr[1:0];
            acc_write = MemWrite;
        end
        go_resp      = (accept && (WAIT == 0)) || ((state == ST_WAIT) && (cnt == '0));
        commit_write = (state == ST_RESP) && hold_write && !hold_mis && !reset;
    end

    // Storage is not reset; the write lands on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (commit_write) begin
            mem[hold_idx] <= hold_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hold_idx   <= '0;
            hold_mis   <= 1'b0;
            hold_write <= 1'b0;
            hold_data  <= '0;
            ReadData   <= '0;
            MemReady   <= 1'b0;
            AdrErr     <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            MemReady <= 1'b0;
            AdrErr   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        hold_idx   <= acc_idx;
                        hold_mis   <= acc_mis;
                        hold_write <= acc_write;
                        hold_data  <= WriteData;
                        if (!go_resp) begin
                            state <= ST_WAIT;
                            cnt   <= CNT_LOAD;
                            Busy  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!go_resp) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
            // Entering RESP: raise the pulse and load read data for the whole RESP cycle.
            if (go_resp) begin
                state    <= ST_RESP;
                Busy     <= 1'b1;
                MemReady <= 1'b1;
                AdrErr   <= acc_mis;
                if (acc_mis) begin
                    ReadData <= '0;
                end else if (!acc_write) begin
                    ReadData <= mem[acc_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Scoreboard bench for mem_wait_responder: a WAIT=2 instance and a WAIT=0 instance.
module tb_mem_wait_responder;

    localparam int WAIT2 = 2;
    localparam int WAIT0 = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;

    logic        req2 = 1'b0, we2 = 1'b0;
    logic [31:0] adr2 = '0, wd2 = '0;
    logic [31:0] rd2;
    logic        rdy2, err2, busy2;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] adr0 = '0, wd0 = '0;
    logic [31:0] rd0;
    logic        rdy0, err0, busy0;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b0;

    exp_t        q2[$];
    exp_t        q0[$];
    logic [31:0] mdl2 [int];
    logic [31:0] mdl0 [int];
    logic [31:0] exp_rd2 = '0;
    logic [31:0] exp_rd0 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_wait_responder #(.WIDTH(32), .DEPTH_LOG2(8), .WAIT(WAIT2)) u_dut2 (
        .clk(clk), .reset(reset), .MemReq(req2), .MemWrite(we2), .Adr(adr2),
        .WriteData(wd2), .ReadData(rd2), .MemReady(rdy2), .AdrErr(err2), .Busy(busy2)
    );

    mem_wait_responder #(.WIDTH(32), .DEPTH_LOG2(8), .WAIT(WAIT0)) u_dut0 (
        .clk(clk), .reset(reset), .MemReq(req0), .MemWrite(we0), .Adr(adr0),
        .WriteData(wd0), .ReadData(rd0), .MemReady(rdy0), .AdrErr(err0), .Busy(busy0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: response expected WAIT+1 negedges after the drive point.
    task automatic expect2(input logic wr, input logic [31:0] adr, input logic [31:0] data);
        exp_t e;
        int   idx;
        idx   = int'(adr[9:2]);
        e.err = |adr[1:0];
        if (e.err)   exp_rd2   = '0;
        else if (wr) mdl2[idx] = data;
        else         exp_rd2   = mdl2[idx];
        e.rd  = exp_rd2;
        e.cyc = cyc + WAIT2 + 1;
        q2.push_back(e);
    endtask

    task automatic expect0(input logic wr, input logic [31:0] adr, input logic [31:0] data);
        exp_t e;
        int   idx;
        idx   = int'(adr[9:2]);
        e.err = |adr[1:0];
        if (e.err)   exp_rd0   = '0;
        else if (wr) mdl0[idx] = data;
        else         exp_rd0   = mdl0[idx];
        e.rd  = exp_rd0;
        e.cyc = cyc + WAIT0 + 1;
        q0.push_back(e);
    endtask

    // Single request on the WAIT=2 instance; inputs are scrambled right after acceptance.
    task automatic issue2(input logic wr, input logic [31:0] adr, input logic [31:0] data);
        @(negedge clk);
        req2 = 1'b1; we2 = wr; adr2 = adr; wd2 = data;
        expect2(wr, adr, data);
        @(negedge clk);
        req2 = 1'b0; we2 = ~wr; adr2 = 32'h0000_0013; wd2 = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !reset) begin
            if (rdy2) begin
                if (q2.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dut2 MemReady: got 1 with no request pending, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q2.pop_front();
                    check("dut2 ReadData", rd2, e.rd);
                    check("dut2 AdrErr", 32'(err2), 32'(e.err));
                    check("dut2 MemReady cycle", 32'(cyc), 32'(e.cyc));
                    check("dut2 Busy in RESP", 32'(busy2), 32'd1);
                end
            end else begin
                check("dut2 AdrErr without MemReady", 32'(err2), 32'd0);
            end
            if (rdy0) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dut0 MemReady: got 1 with no request pending, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q0.pop_front();
                    check("dut0 ReadData", rd0, e.rd);
                    check("dut0 AdrErr", 32'(err0), 32'(e.err));
                    check("dut0 MemReady cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset asserted mid-cycle must act without a clock edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset MemReady", 32'(rdy2), 32'd0);
        check("reset Busy", 32'(busy2), 32'd0);
        check("reset ReadData", rd2, 32'd0);
        check("reset dut0 Busy", 32'(busy0), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle MemReady", 32'(rdy2), 32'd0);
            check("idle Busy", 32'(busy2), 32'd0);
            check("idle ReadData", rd2, 32'd0);
        end

        issue2(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        issue2(1'b0, 32'h0000_0010, 32'h0);
        repeat (2) @(negedge clk);
        check("dut2 ReadData holds", rd2, 32'hDEAD_BEEF);

        issue2(1'b1, 32'h0000_0400, 32'h1234_5678);
        issue2(1'b0, 32'h0000_0000, 32'h0);

        issue2(1'b1, 32'h0000_0013, 32'hFFFF_FFFF);
        issue2(1'b0, 32'h0000_0010, 32'h0);
        issue2(1'b0, 32'h0000_0011, 32'h0);

        // WAIT=0 back-to-back writes with MemReq held; odd cycles present decoy inputs.
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            req0 = 1'b1; we0 = 1'b1;
            if (i % 2 == 0) begin
                adr0 = 32'(4 * (i / 2));
                wd0  = 32'h1000_0000 + 32'(i);
                expect0(1'b1, adr0, wd0);
            end else begin
                adr0 = 32'(4 * (i / 2 + 16));
                wd0  = 32'hBAD0_0000 + 32'(i);
            end
            @(negedge clk);
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            req0 = 1'b1;
            if (i % 2 == 0) begin
                we0  = 1'b0;
                adr0 = 32'(4 * (i / 2));
                expect0(1'b0, adr0, 32'h0);
            end else begin
                we0  = 1'b1;
                adr0 = 32'(4 * (i / 2 + 16)) + 32'd1;
                wd0  = 32'hBAD1_0000 + 32'(i);
            end
            @(negedge clk);
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while the write sits in its first WAIT cycle drops it.
        issue2(1'b1, 32'h0000_0020, 32'h1111_1111);
        issue2(1'b0, 32'h0000_0010, 32'h0);
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b1; adr2 = 32'h0000_0020; wd2 = 32'hAAAA_5555;
        @(negedge clk);
        req2 = 1'b0;
        check("dut2 Busy in WAIT", 32'(busy2), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid-WAIT reset Busy", 32'(busy2), 32'd0);
        check("mid-WAIT reset MemReady", 32'(rdy2), 32'd0);
        check("mid-WAIT reset ReadData", rd2, 32'd0);
        exp_rd2 = '0;
        exp_rd0 = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post-reset Busy", 32'(busy2), 32'd0);
        end
        issue2(1'b0, 32'h0000_0020, 32'h0);

        repeat (4) @(negedge clk);
        check("dut2 responses outstanding", 32'(q2.size()), 32'd0);
        check("dut0 responses outstanding", 32'(q0.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
